// File: rtl/adder_pkg.sv
// Shared definitions for the slice-based adder sequencers.
//   state_e    : sequencer FSM states (IDLE, RUN, DONE)
//   SLICE_W    : width of the external prefix adder slice
//   slice_cout : rebuilds a slice carry-out from the operand MSBs and the
//                sum MSB, because the adder has no carry output
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int SLICE_W = 16;

   // A carry out of the MSB occurs when both operand MSBs are set (generate),
   // or when exactly one is set (propagate) and the sum MSB came out 0,
   // because that means a carry arrived into the MSB and passed through it.
   function automatic logic slice_cout(input logic x, input logic y, input logic s);
      return (x & y) | ((x ^ y) & ~s);
   endfunction

endpackage

// File: rtl/add_slice_sequencer.sv
// Operand sequencer for the external combinational 16-bit prefix adder.
// A full-width add request is split into SLICE-wide pieces. One piece goes
// through the adder per cycle, least-significant piece first. The carry of
// each piece is rebuilt from the adder sum and fed into the next piece.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   in_valid/in_ready      request handshake; in_a, in_b, in_cin are the operands
//   adder_a/adder_b/adder_cin  slice operands driven to the adder (0 outside RUN)
//   adder_s                slice sum returned combinationally by the adder
//   out_valid/out_ready    result handshake; out_sum and out_cout are the result
//
// WIDTH must be a multiple of SLICE.
module add_slice_sequencer
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = SLICE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic [SLICE-1:0] adder_a,
   output logic [SLICE-1:0] adder_b,
   output logic             adder_cin,
   input  logic [SLICE-1:0] adder_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q;
   logic              cin_q;
   logic [WIDTH-1:0]  opa_q, opb_q;
   logic [WIDTH-1:0]  sum_q;
   logic              accept;
   logic              last;

   assign accept = in_valid & in_ready;
   assign last   = (idx_q == IDXW'(NSLICE - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the values from before the clock edge.
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path through this
      // block leaves a signal unassigned and no latch is inferred.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // Taking a new request in the same cycle the result leaves
            // allows back-to-back operation without an idle cycle.
            in_ready  = out_ready;
            if (out_ready) state_d = in_valid ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Slice select toward the adder. The loop builds a mux on idx and avoids
   // a variable part-select.
   always_comb begin
      adder_a   = '0;
      adder_b   = '0;
      adder_cin = 1'b0;
      if (state_q == RUN) begin
         for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
               adder_a = opa_q[i*SLICE +: SLICE];
               adder_b = opb_q[i*SLICE +: SLICE];
            end
         end
         adder_cin = (idx_q == '0) ? cin_q : carry_q;
      end
   end

   // Operand capture, slice counter, carry chain and sum assembly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         cin_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
      end else if (accept) begin
         opa_q <= in_a;
         opb_q <= in_b;
         cin_q <= in_cin;
         idx_q <= '0;
      end else if (state_q == RUN) begin
         for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) sum_q[i*SLICE +: SLICE] <= adder_s;
         end
         carry_q <= slice_cout(adder_a[SLICE-1], adder_b[SLICE-1], adder_s[SLICE-1]);
         if (!last) idx_q <= idx_q + IDXW'(1);
      end
   end

   // The carry register holds the final slice carry from the last RUN cycle
   // until the next request starts, so it is also the result carry.
   assign out_sum  = sum_q;
   assign out_cout = carry_q;

endmodule
